i2c_register_target: RTL and testbench

// I2C target (slave) for the on-board register bus. Answers one 7-bit address and

---
 rtl/i2c_register_target.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_register_target.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_register_target.sv
// I2C target answering one 7-bit address and exposing a 256-entry register space
// through single-cycle write/read strobes. SCL and SDA are oversampled on the system clock.
`timescale 1ns/1ps
module i2c_register_target #(
    parameter logic [6:0] ADDRESS = 7'h50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_input,
    input  logic       sda_input,
    output logic       sda_output,
    output logic       reg_write,
    output logic       reg_read,
    output logic [7:0] reg_address,
    output logic [7:0] reg_write_data,
    input  logic [7:0] reg_read_data,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, MASTER_ACK, WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, pointer_q, pointer_d;
    logic [7:0] reg_address_q, reg_address_d, reg_write_data_q, reg_write_data_d;
    logic       rw_q, rw_d, load_q, load_d, sda_out_q, sda_out_d;
    logic       reg_write_q, reg_write_d, reg_read_q, reg_read_d, busy_q, busy_d;
    logic       scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;
    logic [7:0] rx_byte_s;

    // Bus event decode: bit [1] is the synchronized level, bit [2] its previous value
    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl_input};
        sda_sync_d = {sda_sync_q[1:0], sda_input};
        sda_s      = sda_sync_q[1];
        scl_rise_s = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall_s = ~scl_sync_q[1] & scl_sync_q[2];
        start_s    = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
        stop_s     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
        rx_byte_s  = {rx_q[6:0], sda_s};
    end

    // Protocol FSM: next state, shift registers, strobes and SDA drive
    always_comb begin
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        rx_d             = rx_q;
        pointer_d        = pointer_q;
        rw_d             = rw_q;
        sda_out_d        = sda_out_q;
        reg_address_d    = reg_address_q;
        reg_write_data_d = reg_write_data_q;
        busy_d           = busy_q;
        reg_write_d      = 1'b0;
        reg_read_d       = 1'b0;
        load_d           = reg_read_q;
        // Read data arrives one clock after the read strobe
        if (load_q) begin
            tx_d = reg_read_data;
        end else begin
            tx_d = tx_q;
        end

        if (start_s) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else if (stop_s) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WRITE_DATA: begin
                    if (scl_fall_s) begin
                        sda_out_d = 1'b1;
                    end else if (scl_rise_s) begin
                        rx_d      = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ADDR: begin
                                    if (rx_byte_s[7:1] == ADDRESS) begin
                                        state_d       = ADDR_ACK;
                                        busy_d        = 1'b1;
                                        rw_d          = rx_byte_s[0];
                                        reg_read_d    = rx_byte_s[0];
                                        reg_address_d = pointer_q;
                                    end else begin
                                        state_d = IDLE;
                                    end
                                end
                                REG: begin
                                    pointer_d = rx_byte_s;
                                    state_d   = REG_ACK;
                                end
                                default: begin
                                    reg_write_d      = 1'b1;
                                    reg_address_d    = pointer_q;
                                    reg_write_data_d = rx_byte_s;
                                    pointer_d        = pointer_q + 8'd1;
                                    state_d          = WRITE_ACK;
                                end
                            endcase
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                // ACK is held low from the falling edge after bit 8 until the one after bit 9
                ADDR_ACK, REG_ACK, WRITE_ACK: begin
                    if (scl_fall_s) begin
                        sda_out_d = 1'b0;
                    end else if (scl_rise_s) begin
                        bit_cnt_d = 3'd0;
                        if (state_q == ADDR_ACK) begin
                            state_d = rw_q ? READ_DATA : REG;
                        end else begin
                            state_d = WRITE_DATA;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                READ_DATA: begin
                    if (scl_fall_s) begin
                        sda_out_d = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b1};
                    end else if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = MASTER_ACK;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                MASTER_ACK: begin
                    if (scl_fall_s) begin
                        sda_out_d = 1'b1;
                    end else if (scl_rise_s) begin
                        pointer_d = pointer_q + 8'd1;
                        bit_cnt_d = 3'd0;
                        if (!sda_s) begin
                            reg_read_d    = 1'b1;
                            reg_address_d = pointer_q + 8'd1;
                            state_d       = READ_DATA;
                        end else begin
                            state_d = WAIT;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    sda_out_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            scl_sync_q       <= 3'b111;
            sda_sync_q       <= 3'b111;
            bit_cnt_q        <= 3'd0;
            rx_q             <= 8'h00;
            tx_q             <= 8'hFF;
            pointer_q        <= 8'h00;
            rw_q             <= 1'b0;
            load_q           <= 1'b0;
            sda_out_q        <= 1'b1;
            reg_write_q      <= 1'b0;
            reg_read_q       <= 1'b0;
            reg_address_q    <= 8'h00;
            reg_write_data_q <= 8'h00;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            scl_sync_q       <= scl_sync_d;
            sda_sync_q       <= sda_sync_d;
            bit_cnt_q        <= bit_cnt_d;
            rx_q             <= rx_d;
            tx_q             <= tx_d;
            pointer_q        <= pointer_d;
            rw_q             <= rw_d;
            load_q           <= load_d;
            sda_out_q        <= sda_out_d;
            reg_write_q      <= reg_write_d;
            reg_read_q       <= reg_read_d;
            reg_address_q    <= reg_address_d;
            reg_write_data_q <= reg_write_data_d;
            busy_q           <= busy_d;
        end
    end

    assign sda_output     = sda_out_q;
    assign reg_write      = reg_write_q;
    assign reg_read       = reg_read_q;
    assign reg_address    = reg_address_q;
    assign reg_write_data = reg_write_data_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_i2c_register_target.sv
// Directed bench for i2c_register_target: bit-banged I2C master, register-file model
// and strobe monitor; every expected value is a hand-computed constant.
`timescale 1ns/1ps
module tb_i2c_register_target;
    localparam time Q = 80ns;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl_input = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_output, reg_write, reg_read, busy;
    logic [7:0] reg_address, reg_write_data;
    logic [7:0] reg_read_data = 8'h00;
    logic [7:0] mem [256];
    logic [15:0] wr_log [$];
    logic [7:0]  rd_log [$];
    int both_cnt = 0, low_cnt = 0, busy_cnt = 0;
    int n_cmp = 0, n_err = 0;

    assign sda_bus = sda_m & sda_output;

    i2c_register_target #(.ADDRESS(7'h50)) dut (
        .clock(clock), .reset(reset), .scl_input(scl_input), .sda_input(sda_bus),
        .sda_output(sda_output), .reg_write(reg_write), .reg_read(reg_read),
        .reg_address(reg_address), .reg_write_data(reg_write_data),
        .reg_read_data(reg_read_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Register-file model and strobe monitor
    always @(posedge clock) begin
        if (reg_write) wr_log.push_back({reg_address, reg_write_data});
        if (reg_read) rd_log.push_back(reg_address);
        if (reg_read) reg_read_data <= mem[reg_address];
        if (reg_write && reg_read) both_cnt <= both_cnt + 1;
        if (!sda_output) low_cnt <= low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl_input = 1'b1; #Q; sda_m = 1'b0; #Q; scl_input = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl_input = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; #Q; scl_input = 1'b1; #(2*Q); scl_input = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q; scl_input = 1'b1; #Q; ack = sda_bus; #Q; scl_input = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] data);
        data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; #Q; scl_input = 1'b1; #Q; data = {data[6:0], sda_bus}; #Q; scl_input = 1'b0; #Q;
        end
        send_bit(nack);
        sda_m = 1'b1;
    endtask

    initial begin
        logic [4:0] a;
        logic [7:0] d0, d1, addr_w;
        int wb, rb, lb, bb;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h20] = 8'h3C; mem[8'h21] = 8'h7E; mem[8'h22] = 8'h5A; mem[8'h00] = 8'h99;

        // Reset values
        #40;
        check("rst_sda", 32'(sda_output), 32'd1);
        check("rst_wr", 32'(reg_write), 32'd0);
        check("rst_rd", 32'(reg_read), 32'd0);
        check("rst_addr", 32'(reg_address), 32'h00);
        check("rst_wdata", 32'(reg_write_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #40;

        // Single register write
        wb = wr_log.size();
        i2c_start();
        write_byte(8'hA0, a[0]); write_byte(8'h12, a[1]); write_byte(8'hA5, a[2]);
        check("t1_acks", 32'(a[2:0]), 32'd0);
        check("t1_busy_on", 32'(busy), 32'd1);
        i2c_stop();
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_nwr", 32'(wr_log.size() - wb), 32'd1);
        check("t1_wr0", 32'(wr_log[wb]), 32'h12A5);

        // Burst write with pointer wrap
        wb = wr_log.size();
        i2c_start();
        write_byte(8'hA0, a[0]); write_byte(8'hFE, a[1]);
        write_byte(8'h11, a[2]); write_byte(8'h22, a[3]); write_byte(8'h33, a[4]);
        i2c_stop();
        check("t2_acks", 32'(a), 32'd0);
        check("t2_nwr", 32'(wr_log.size() - wb), 32'd3);
        check("t2_wr0", 32'(wr_log[wb]), 32'hFE11);
        check("t2_wr1", 32'(wr_log[wb+1]), 32'hFF22);
        check("t2_wr2", 32'(wr_log[wb+2]), 32'h0033);

        // Foreign address 0x51 is never acknowledged
        wb = wr_log.size(); rb = rd_log.size(); lb = low_cnt; bb = busy_cnt;
        i2c_start();
        write_byte(8'hA2, a[0]); write_byte(8'h34, a[1]);
        i2c_stop();
        check("t3_nacks", 32'(a[1:0]), 32'd3);
        check("t3_sda_low", 32'(low_cnt - lb), 32'd0);
        check("t3_nwr", 32'(wr_log.size() - wb), 32'd0);
        check("t3_nrd", 32'(rd_log.size() - rb), 32'd0);
        check("t3_busy", 32'(busy_cnt - bb), 32'd0);

        // Register select, repeated START, two-byte read ending in NACK
        wb = wr_log.size(); rb = rd_log.size();
        i2c_start();
        write_byte(8'hA0, a[0]); write_byte(8'h20, a[1]);
        i2c_start();
        write_byte(8'hA1, a[2]);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        #Q;
        check("t4_acks", 32'(a[2:0]), 32'd0);
        check("t4_busy_nack", 32'(busy), 32'd0);
        check("t4_sda_rel", 32'(sda_output), 32'd1);
        i2c_stop();
        check("t4_d0", 32'(d0), 32'h3C);
        check("t4_d1", 32'(d1), 32'h7E);
        check("t4_nrd", 32'(rd_log.size() - rb), 32'd2);
        check("t4_rd0", 32'(rd_log[rb]), 32'h20);
        check("t4_rd1", 32'(rd_log[rb+1]), 32'h21);
        check("t4_nwr", 32'(wr_log.size() - wb), 32'd0);
        // Pointer continues at 0x22
        i2c_start();
        write_byte(8'hA1, a[0]);
        read_byte(1'b1, d0);
        i2c_stop();
        check("t4_ptr_rd", 32'(rd_log[rb+2]), 32'h22);
        check("t4_ptr_data", 32'(d0), 32'h5A);

        // STOP after four data bits aborts the byte
        wb = wr_log.size();
        i2c_start();
        write_byte(8'hA0, a[0]); write_byte(8'h40, a[1]);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        check("t5_nwr", 32'(wr_log.size() - wb), 32'd0);
        check("t5_sda", 32'(sda_output), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        i2c_start();
        write_byte(8'hA0, a[0]); write_byte(8'h41, a[1]); write_byte(8'h77, a[2]);
        i2c_stop();
        check("t5_acks", 32'(a[2:0]), 32'd0);
        check("t5_wr", 32'(wr_log[wb]), 32'h4177);

        // Reset asserted while the address ACK is being driven
        rb = rd_log.size();
        addr_w = 8'hA0;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_w[i]);
        sda_m = 1'b1; #Q; scl_input = 1'b1; #Q;
        check("t6_ack_driven", 32'(sda_output), 32'd0);
        reset = 1'b1;
        #10;
        check("t6_sda", 32'(sda_output), 32'd1);
        check("t6_wr", 32'(reg_write), 32'd0);
        check("t6_rd", 32'(reg_read), 32'd0);
        check("t6_addr", 32'(reg_address), 32'h00);
        check("t6_wdata", 32'(reg_write_data), 32'h00);
        check("t6_busy", 32'(busy), 32'd0);
        #20;
        reset = 1'b0;
        #Q; scl_input = 1'b0; #Q;
        send_bit(1'b0); send_bit(1'b1);
        check("t6_ignored", 32'(sda_output), 32'd1);
        i2c_start();
        write_byte(8'hA1, a[0]);
        read_byte(1'b1, d0);
        i2c_stop();
        check("t6_ack", 32'(a[0]), 32'd0);
        check("t6_ptr_rd", 32'(rd_log[rb]), 32'h00);
        check("t6_ptr_data", 32'(d0), 32'h99);

        check("strobe_overlap", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
